fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV64 core; it feeds the instruction and PC to the decode stage, where the opcode field drives the control unit. It owns the PC, issues reads to a synchronous 1-cycle-latency instruction memory, and absorbs hazard-unit stalls through a one-entry skid buffer. It also applies ID-stage redirects from JAL, JALR and taken branches by killing wrong-path fetches.

---
 rtl/core_pkg.sv | 38 +++
 rtl/fetch_skid_buffer.sv | 36 +++
 rtl/fetch_stage.sv | 99 +++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage RV64 core: widths, reset defaults,
// the fetch bubble encoding and the opcode constants used by the control unit.
package core_pkg;

   localparam int          XLEN         = 64;
   localparam logic [63:0] RESET_PC_DEF = 64'h0;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

   localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
   localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b001_1011;
   localparam logic [6:0] OPC_STORE    = 7'b010_0011;
   localparam logic [6:0] OPC_OP       = 7'b011_0011;
   localparam logic [6:0] OPC_LUI      = 7'b011_0111;
   localparam logic [6:0] OPC_OP32     = 7'b011_1011;
   localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
   localparam logic [6:0] OPC_JALR     = 7'b110_0111;
   localparam logic [6:0] OPC_JAL      = 7'b110_1111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

   // Fetch occupancy, derived from the response/skid flags rather than stored.
   typedef enum logic [1:0] {
      MODE_FILL = 2'd0,
      MODE_RUN  = 2'd1,
      MODE_HOLD = 2'd2
   } fetch_mode_e;

   function automatic fetch_mode_e fetch_mode(input logic resp_valid, input logic skid_valid);
      if (skid_valid)
         return MODE_HOLD;
      else if (resp_valid)
         return MODE_RUN;
      else
         return MODE_FILL;
   endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for an instruction response that arrives while the
// IF/ID register is stalled.
module fetch_skid_buffer
   import core_pkg::*;
#(
   parameter int XLEN = core_pkg::XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            drain,
   input  logic            clear,
   input  logic [31:0]     instr_in,
   input  logic [XLEN-1:0] pc_in,
   output logic            valid,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] pc
);

   always_ff @(posedge clk) begin
      if (reset || clear)
         valid <= 1'b0;
      else if (load)
         valid <= 1'b1;
      else if (drain)
         valid <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (load) begin
         instr <= instr_in;
         pc    <= pc_in;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads a 1-cycle synchronous instruction
// memory, and drives the IF/ID register with stall skid and redirect kill.
module fetch_stage
   import core_pkg::*;
#(
   parameter int             XLEN      = core_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(core_pkg::RESET_PC_DEF),
   parameter logic [31:0]    NOP_INSTR = core_pkg::NOP_INSTR
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_en_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic [31:0]     imem_data_i,
   output logic            if_id_valid_o,
   output logic [31:0]     if_id_instr_o,
   output logic [XLEN-1:0] if_id_pc_o
);

   logic [XLEN-1:0] pc_q;
   logic            resp_valid_q;
   logic [XLEN-1:0] resp_pc_q;
   logic            skid_valid_q;
   logic [31:0]     skid_instr_q;
   logic [XLEN-1:0] skid_pc_q;

   logic            advance;
   logic            skid_load;
   logic [XLEN-1:0] target_pc;

   assign advance     = !redirect_i && !stall_i;
   assign imem_en_o   = !reset_i && advance;
   assign imem_addr_o = pc_q;
   assign skid_load   = stall_i && !redirect_i && resp_valid_q;
   assign target_pc   = redirect_pc_i & ~XLEN'(3);

   fetch_skid_buffer #(
      .XLEN(XLEN)
   ) u_skid (
      .clk      (clk_i),
      .reset    (reset_i),
      .load     (skid_load),
      .drain    (advance),
      .clear    (redirect_i),
      .instr_in (imem_data_i),
      .pc_in    (resp_pc_q),
      .valid    (skid_valid_q),
      .instr    (skid_instr_q),
      .pc       (skid_pc_q)
   );

   // Stage 0: program counter and in-flight response tracking
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pc_q         <= RESET_PC;
         resp_valid_q <= 1'b0;
      end else if (redirect_i) begin
         pc_q         <= target_pc;
         resp_valid_q <= 1'b0;
      end else if (stall_i) begin
         resp_valid_q <= 1'b0;
      end else begin
         pc_q         <= pc_q + XLEN'(4);
         resp_valid_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (advance)
         resp_pc_q <= pc_q;
   end

   // Stage 1: IF/ID register; skid entry is older than the arriving response
   always_ff @(posedge clk_i) begin
      if (reset_i || redirect_i) begin
         if_id_valid_o <= 1'b0;
         if_id_instr_o <= NOP_INSTR;
         if_id_pc_o    <= '0;
      end else if (!stall_i) begin
         if (skid_valid_q) begin
            if_id_valid_o <= 1'b1;
            if_id_instr_o <= skid_instr_q;
            if_id_pc_o    <= skid_pc_q;
         end else if (resp_valid_q) begin
            if_id_valid_o <= 1'b1;
            if_id_instr_o <= imem_data_i;
            if_id_pc_o    <= resp_pc_q;
         end else begin
            if_id_valid_o <= 1'b0;
            if_id_instr_o <= NOP_INSTR;
            if_id_pc_o    <= '0;
         end
      end
   end

endmodule
